// File: rtl/tdm_demux_1x8_pkg.sv
// Shared types and constants for the 1-to-8 TDM demultiplexer.
package tdm_demux_1x8_pkg;

  localparam int NUM_CH = 8;
  localparam int SLOT_W = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/tdm_sync_fsm.sv
// Frame-alignment FSM: hunts for frame_sync, qualifies it over LOCK_FRAMES
// frames, and flags misplaced or missing syncs.
module tdm_sync_fsm
  import tdm_demux_1x8_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   beat_i,
  input  logic   sync_i,
  input  logic   slot_zero_i,
  output state_e state_o,
  output logic   locked_o,
  output logic   sync_err_o
);

  localparam logic       ONE_FRAME = (LOCK_FRAMES == 1);
  localparam logic [3:0] LOCK_CNT  = 4'(LOCK_FRAMES);

  state_e     state_q;
  logic [3:0] good_q;
  logic       locked_q;
  logic       sync_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      good_q     <= '0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= 1'b0;
      if (beat_i) begin
        if (state_q == HUNT) begin
          if (sync_i) begin
            good_q <= 4'd1;
            if (ONE_FRAME) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              state_q  <= CHECK;
            end
          end
        end else if (sync_i && slot_zero_i) begin
          if (state_q == CHECK) begin
            good_q <= good_q + 4'd1;
            if (good_q + 4'd1 >= LOCK_CNT) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
        end else if (sync_i) begin
          // Sync landed off slot 0: realign on this beat and requalify.
          sync_err_q <= 1'b1;
          good_q     <= 4'd1;
          if (ONE_FRAME) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end else begin
            state_q  <= CHECK;
            locked_q <= 1'b0;
          end
        end else if (slot_zero_i) begin
          sync_err_q <= 1'b1;
          good_q     <= '0;
          state_q    <= HUNT;
          locked_q   <= 1'b0;
        end
      end
    end
  end

  assign state_o    = state_q;
  assign locked_o   = locked_q;
  assign sync_err_o = sync_err_q;

endmodule

// File: rtl/tdm_demux_1x8.sv
// Serial TDM demultiplexer: collects 8 slot bits per frame into a shadow
// register and publishes them on Y once per locked frame.
module tdm_demux_1x8
  import tdm_demux_1x8_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [NUM_CH-1:0] Y,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked,
  output logic [SLOT_W-1:0] slot
);

  state_e              state;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [NUM_CH-1:0]   shadow_q, shadow_d;
  logic [NUM_CH-1:0]   y_q, y_d;
  logic                frame_done_q, frame_done_d;

  tdm_sync_fsm #(
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_sync_fsm (
    .clk         (clk),
    .rst         (rst),
    .beat_i      (din_valid),
    .sync_i      (frame_sync),
    .slot_zero_i (slot_q == '0),
    .state_o     (state),
    .locked_o    (locked),
    .sync_err_o  (sync_err)
  );

  // Any sync beat (good or misplaced) is taken as slot 0; a missing sync or
  // a beat while hunting is dropped with the slot parked at 0.
  always_comb begin
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        shadow_d[0] = din;
        slot_d      = SLOT_W'(1);
      end else if (state != HUNT && slot_q != '0) begin
        shadow_d[slot_q] = din;
        slot_d           = slot_q + 1'b1;
        if (state == LOCKED && slot_q == SLOT_W'(NUM_CH - 1)) begin
          y_d          = {din, shadow_q[NUM_CH-2:0]};
          frame_done_d = 1'b1;
        end
      end else begin
        slot_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q       <= '0;
      shadow_q     <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign Y          = y_q;
  assign frame_done = frame_done_q;
  assign slot       = slot_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed bench for tdm_demux_1x8: table-driven frame sequences plus
// hand-written error, reset and single-frame-lock scenarios.
module tb_tdm_demux_1x8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;

  logic [7:0] y1, y2;
  logic       fd1, fd2, se1, se2, lk1, lk2;
  logic [2:0] sl1, sl2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        v;
    logic        d;
    logic        fs;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  tdm_demux_1x8 #(.LOCK_FRAMES(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .Y(y1), .frame_done(fd1), .sync_err(se1), .locked(lk1), .slot(sl1)
  );

  tdm_demux_1x8 #(.LOCK_FRAMES(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .Y(y2), .frame_done(fd2), .sync_err(se2), .locked(lk2), .slot(sl2)
  );

  function automatic logic [13:0] pk(input logic [7:0] y, input logic fd,
                                     input logic se, input logic lk, input logic [2:0] sl);
    return {y, fd, se, lk, sl};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual{Y,fd,se,lk,slot}=%h_%b%b%b_%0d required=%h_%b%b%b_%0d",
               name, act[13:6], act[5], act[4], act[3], act[2:0],
               exp[13:6], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  function automatic logic [13:0] out1();
    return {y1, fd1, se1, lk1, sl1};
  endfunction

  function automatic logic [13:0] out2();
    return {y2, fd2, se2, lk2, sl2};
  endfunction

  task automatic step(input logic v, input logic d, input logic fs);
    @(negedge clk);
    din_valid  = v;
    din        = d;
    frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    din_valid  = 1'b0;
    din        = 1'b0;
    frame_sync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One frame of beats (slot k carries b[k]); optional 5-cycle idle gap after beat gap_at.
  task automatic add_frame(input logic [7:0] b, input logic lk, input logic [7:0] yb,
                           input logic [7:0] ya, input logic fd, input int gap_at);
    vec_t e;
    for (int k = 0; k < 8; k++) begin
      e.v   = 1'b1;
      e.d   = b[k];
      e.fs  = (k == 0);
      e.exp = pk((k == 7) ? ya : yb, fd && (k == 7), 1'b0, lk, 3'((k + 1) % 8));
      vecs.push_back(e);
      if (k == gap_at) begin
        for (int g = 0; g < 5; g++) begin
          e.v   = 1'b0;
          e.d   = g[0];
          e.fs  = ~g[0];
          e.exp = pk(yb, 1'b0, 1'b0, lk, 3'(k + 1));
          vecs.push_back(e);
        end
      end
    end
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].fs);
      check($sformatf("%s_v%0d", tag, i), out1(), vecs[i].exp);
    end
  endtask

  logic [7:0] b;

  initial begin
    #3;
    check("reset_lf2", out1(), pk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    check("reset_lf1", out2(), pk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    do_reset();

    // Three back-to-back frames: lock on the second sync, output after frames 2 and 3.
    vecs.delete();
    add_frame(8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, -1);
    add_frame(8'hA5, 1'b1, 8'h00, 8'hA5, 1'b1, -1);
    add_frame(8'hA5 ^ 8'h99, 1'b1, 8'hA5, 8'h3C, 1'b1, -1);
    run_table("frames");

    // Same frames with idle gaps (frame_sync toggling while invalid).
    do_reset();
    vecs.delete();
    add_frame(8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, 2);
    add_frame(8'hA5, 1'b1, 8'h00, 8'hA5, 1'b1, 3);
    add_frame(8'h3C, 1'b1, 8'hA5, 8'h3C, 1'b1, 6);
    run_table("gaps");

    // Misplaced sync on slot 5 while locked.
    b = 8'h0F;
    for (int k = 0; k < 5; k++) step(1'b1, b[k], k == 0);
    check("pre_misplaced", out1(), pk(8'h3C, 1'b0, 1'b0, 1'b1, 3'd5));
    step(1'b1, 1'b1, 1'b1);
    check("misplaced_err", out1(), pk(8'h3C, 1'b0, 1'b1, 1'b0, 3'd1));
    step(1'b1, 1'b0, 1'b0);
    check("misplaced_err_clr", out1(), pk(8'h3C, 1'b0, 1'b0, 1'b0, 3'd2));
    for (int k = 2; k < 8; k++) step(1'b1, 1'b1, 1'b0);
    check("broken_no_done", out1(), pk(8'h3C, 1'b0, 1'b0, 1'b0, 3'd0));
    b = 8'h5A;
    step(1'b1, b[0], 1'b1);
    check("relock", out1(), pk(8'h3C, 1'b0, 1'b0, 1'b1, 3'd1));
    for (int k = 1; k < 8; k++) step(1'b1, b[k], 1'b0);
    check("relock_frame", out1(), pk(8'h5A, 1'b1, 1'b0, 1'b1, 3'd0));

    // Missing sync at slot 0 while locked.
    step(1'b1, 1'b0, 1'b0);
    check("missing_sync", out1(), pk(8'h5A, 1'b0, 1'b1, 1'b0, 3'd0));
    step(1'b0, 1'b0, 1'b0);
    check("missing_sync_clr", out1(), pk(8'h5A, 1'b0, 1'b0, 1'b0, 3'd0));
    step(1'b1, 1'b1, 1'b0);
    check("hunt_discard", out1(), pk(8'h5A, 1'b0, 1'b0, 1'b0, 3'd0));

    // Relock, then async reset mid-frame at slot 3.
    b = 8'hA5;
    for (int k = 0; k < 8; k++) step(1'b1, b[k], k == 0);
    b = 8'hC3;
    for (int k = 0; k < 8; k++) step(1'b1, b[k], k == 0);
    check("relock_c3", out1(), pk(8'hC3, 1'b1, 1'b0, 1'b1, 3'd0));
    b = 8'h11;
    for (int k = 0; k < 3; k++) step(1'b1, b[k], k == 0);
    check("pre_reset_slot3", out1(), pk(8'hC3, 1'b0, 1'b0, 1'b1, 3'd3));
    #2 rst = 1'b1;
    #1 check("async_reset", out1(), pk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    #2 rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    check("post_reset_hunt", out1(), pk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    step(1'b1, 1'b1, 1'b1);
    check("post_reset_sync", out1(), pk(8'h00, 1'b0, 1'b0, 1'b0, 3'd1));

    // Single-frame lock on the LOCK_FRAMES=1 instance.
    do_reset();
    b = 8'hFF;
    step(1'b1, b[0], 1'b1);
    check("lf1_locked", out2(), pk(8'h00, 1'b0, 1'b0, 1'b1, 3'd1));
    for (int k = 1; k < 7; k++) step(1'b1, b[k], 1'b0);
    check("lf1_slot6", out2(), pk(8'h00, 1'b0, 1'b0, 1'b1, 3'd7));
    step(1'b1, b[7], 1'b0);
    check("lf1_done", out2(), pk(8'hFF, 1'b1, 1'b0, 1'b1, 3'd0));
    check("lf2_not_done", out1(), pk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0));
    step(1'b0, 1'b0, 1'b0);
    check("lf1_done_clr", out2(), pk(8'hFF, 1'b0, 1'b0, 1'b1, 3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1x8.md
TDM_DEMUX_1X8 -- requirements
Module: tdm_demux_1x8

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 2: number of consecutive correctly aligned frame syncs required to declare lock (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port din, input, 1: serial TDM data bit.
REQ-005 SHALL have port din_valid, input, 1: din and frame_sync are sampled only when this is high (a "beat").
REQ-006 SHALL have port frame_sync, input, 1: marks the beat carrying slot 0.
REQ-007 SHALL have port Y, output, 8: registered channel outputs, Y[k] = slot-k bit of the last complete locked frame.
REQ-008 SHALL have port frame_done, output, 1: one-cycle pulse coincident with each Y update.
REQ-009 SHALL have port sync_err, output, 1: one-cycle pulse on any alignment violation.
REQ-010 SHALL have port locked, output, 1: high while FSM is in LOCKED.
REQ-011 SHALL have port slot, output, 3: slot index the next beat will occupy.

Function
REQ-012 SHALL implement FSM states HUNT, CHECK, LOCKED, plus a slot counter, a good-sync counter (4 bits) and an 8-bit shadow register.
REQ-013 With din_valid low, no state, counter, shadow or output register SHALL change; frame_sync SHALL be ignored.
REQ-014 On each beat outside HUNT, the slot counter SHALL increment modulo 8 (7 wraps to 0), and shadow[slot] <= din.
REQ-015 In HUNT, beats without frame_sync SHALL be discarded with slot held at 0.
REQ-016 In HUNT, a beat with frame_sync SHALL write shadow[0], set slot to 1 and good count to 1, then go to LOCKED if LOCK_FRAMES=1, else CHECK.
REQ-017 In CHECK or LOCKED, a beat with frame_sync at slot 0 is a good sync; in CHECK it SHALL increment the good count and enter LOCKED when the count reaches LOCK_FRAMES.
REQ-018 In CHECK or LOCKED, a beat with frame_sync at slot != 0 SHALL pulse sync_err, treat the beat as slot 0 (shadow[0] <= din, slot <= 1), set good count to 1, and go to CHECK, or to LOCKED if LOCK_FRAMES=1.
REQ-019 In CHECK or LOCKED, a beat at slot 0 without frame_sync SHALL pulse sync_err, discard the beat and go to HUNT with slot 0.
REQ-020 In LOCKED, the slot-7 beat SHALL load Y <= {din, shadow[6:0]} and pulse frame_done on the same edge; latency is 1 clock from that beat, and Y is otherwise held.
REQ-021 Slot-7 beats in CHECK SHALL NOT update Y or pulse frame_done; Y SHALL retain its value through loss of lock.
REQ-022 locked SHALL be registered and SHALL equal (state == LOCKED) with no extra delay.

Reset
REQ-023 While rst is high, the block SHALL immediately (asynchronously) force: state HUNT, slot 0, good count 0, shadow 0, Y=8'h00, frame_done=0, sync_err=0, locked=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release, operation SHALL restart in HUNT on the next rising edge.

Structure
REQ-025 A shared package SHALL hold the state enum (HUNT/CHECK/LOCKED) and the constants NUM_CH=8 and SLOT_W=3.
REQ-026 The sync/lock FSM with the good-sync counter SHALL be a sub-module named tdm_sync_fsm; slot counter, shadow and Y SHALL stay in the top level.

Verification
REQ-027 LOCK_FRAMES=2; three back-to-back frames, slot0..7 bits = 8'hA5, 8'hA5, 8'h3C (slot k = bit k) -> locked rises after the 2nd sync beat; frame_done pulses after frames 2 and 3 only, with Y=8'hA5 then 8'h3C.
REQ-028 Same as REQ-027 with 5 cycles of din_valid=0 (and frame_sync=1 toggling) inserted mid-frame -> identical Y, frame_done timing shifted by 5, no sync_err.
REQ-029 While LOCKED, frame_sync on slot-5 beat -> sync_err one cycle, locked=0, slot=1 next cycle, no frame_done for the broken frame, relock after the next good sync.
REQ-030 While LOCKED, slot-0 beat with frame_sync=0 -> sync_err one cycle, state HUNT, locked=0, slot=0, Y unchanged.
REQ-031 rst pulsed asynchronously between edges at slot 3 of a locked frame -> Y=8'h00, locked=0, slot=0 before the next clk edge.
REQ-032 LOCK_FRAMES=1; single frame 8'hFF -> locked after first sync beat, frame_done with Y=8'hFF at slot 7.
